// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One bit per cycle for MULT/MULTU/DIV/DIVU; MTHI/MTLO complete in a single cycle.
module mdu_iter #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_con_Start,
  input  logic [2:0]       i_con_MdCtrl,
  input  logic [WIDTH-1:0] i_data_A,
  input  logic [WIDTH-1:0] i_data_B,
  input  logic             i_con_Flush,
  output logic [WIDTH-1:0] o_data_Hi,
  output logic [WIDTH-1:0] o_data_Lo,
  output logic             o_con_Busy,
  output logic             o_con_Done,
  output logic             o_con_DivZero
);

  // state | meaning
  // IDLE  | waiting for a request; MTHI/MTLO complete here
  // RUN   | one multiply or divide iteration per edge, WIDTH edges
  // FIX   | sign correction and HI/LO write-back
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     araw_q, araw_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 divzero_q, divzero_d;

  logic                 signed_op;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_up, div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   mul_res;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  always_comb begin
    signed_op = (i_con_MdCtrl == OP_MULT) || (i_con_MdCtrl == OP_DIV);
    a_neg     = signed_op & i_data_A[WIDTH-1];
    b_neg     = signed_op & i_data_B[WIDTH-1];
    a_abs     = a_neg ? -i_data_A : i_data_A;
    b_abs     = b_neg ? -i_data_B : i_data_B;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: a borrow out of the top bit means the trial subtract failed.
    div_up    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_up - {1'b0, opb_q};
    div_next  = div_diff[WIDTH] ? {div_up[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    mul_res   = neg_res_q ? -acc_q : acc_q;
    quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    araw_d    = araw_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divzero_d = divzero_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_con_Start) begin
          if (i_con_MdCtrl <= OP_DIVU) begin
            state_d   = S_RUN;
            cnt_d     = CNT_W'(WIDTH - 1);
            is_div_d  = i_con_MdCtrl[1];
            acc_d     = {{WIDTH{1'b0}}, a_abs};
            opb_d     = b_abs;
            araw_d    = i_data_A;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            divzero_d = 1'b0;
          end else if (i_con_MdCtrl == OP_MTHI) begin
            hi_d      = i_data_A;
            divzero_d = 1'b0;
            done_d    = 1'b1;
          end else if (i_con_MdCtrl == OP_MTLO) begin
            lo_d      = i_data_A;
            divzero_d = 1'b0;
            done_d    = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (i_con_Flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!i_con_Flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = mul_res[2*WIDTH-1:WIDTH];
            lo_d = mul_res[WIDTH-1:0];
          end else if (opb_q == '0) begin
            // Divide by zero: raw dividend to HI, no sign fix-up.
            hi_d      = araw_q;
            lo_d      = '1;
            divzero_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      araw_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      araw_q    <= araw_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign o_data_Hi     = hi_q;
  assign o_data_Lo     = lo_q;
  assign o_con_Busy    = (state_q == S_RUN) || (state_q == S_FIX);
  assign o_con_Done    = done_q;
  assign o_con_DivZero = divzero_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter: 32-bit and 8-bit instances checked against an
// arithmetic reference model of HI/LO results and the fixed latency.
module tb_mdu_iter;

  logic        clk;
  logic        rst_n;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done, dz;

  logic        start8, flush8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic [7:0]  hi8, lo8;
  logic        busy8, done8, dz8;

  int total = 0;
  int bad   = 0;

  mdu_iter #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_con_Start(start), .i_con_MdCtrl(op),
    .i_data_A(a), .i_data_B(b), .i_con_Flush(flush),
    .o_data_Hi(hi), .o_data_Lo(lo), .o_con_Busy(busy), .o_con_Done(done),
    .o_con_DivZero(dz)
  );

  mdu_iter #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_con_Start(start8), .i_con_MdCtrl(op8),
    .i_data_A(a8), .i_data_B(b8), .i_con_Flush(flush8),
    .o_data_Hi(hi8), .o_data_Lo(lo8), .o_con_Busy(busy8), .o_con_Done(done8),
    .o_con_DivZero(dz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Mathematical result of an op at width w: signed ops use true signed integers.
  function automatic void ref_model(input int w, input logic [2:0] o,
                                    input logic [63:0] x, input logic [63:0] y,
                                    output logic [63:0] rhi, output logic [63:0] rlo,
                                    output logic rdz);
    logic [127:0]        mask;
    logic signed [127:0] sx, sy, p, q, r;
    logic                sgn;
    mask = (128'd1 << w) - 128'd1;
    sgn  = (o == 3'd0) || (o == 3'd2);
    sx   = $signed({64'd0, x});
    sy   = $signed({64'd0, y});
    if (sgn && x[w-1]) sx = sx - $signed(128'd1 << w);
    if (sgn && y[w-1]) sy = sy - $signed(128'd1 << w);
    rdz = 1'b0;
    if (o < 3'd2) begin
      p   = sx * sy;
      rlo = 64'(p & mask);
      rhi = 64'((p >> w) & mask);
    end else if (y == 64'd0) begin
      rlo = 64'(mask);
      rhi = x;
      rdz = 1'b1;
    end else begin
      q   = sx / sy;
      r   = sx % sy;
      rlo = 64'(q & mask);
      rhi = 64'(r & mask);
    end
  endfunction

  // Drives a request through its start edge; returns #1 into cycle 1.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc, output int nbusy, output int nchg);
    logic [31:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    cyc = c0; nbusy = 0; nchg = 0;
    while (!done && cyc < 80) begin
      if (busy) nbusy++;
      if (hi !== hi0 || lo !== lo0) nchg++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_check(input string tag, input logic [2:0] o,
                           input logic [31:0] x, input logic [31:0] y);
    int cyc, nbusy, nchg;
    logic [63:0] ehi, elo;
    logic        edz;
    ref_model(32, o, {32'd0, x}, {32'd0, y}, ehi, elo, edz);
    do_op(o, x, y);
    wait_done(1, cyc, nbusy, nchg);
    chk({tag, ".latency"}, 64'(cyc), 64'd34);
    chk({tag, ".busy_cycles"}, 64'(nbusy), 64'd33);
    chk({tag, ".hold"}, 64'(nchg), 64'd0);
    chk({tag, ".hi"}, {32'd0, hi}, ehi);
    chk({tag, ".lo"}, {32'd0, lo}, elo);
    chk({tag, ".divzero"}, {63'd0, dz}, {63'd0, edz});
  endtask

  task automatic run8(input string tag, input logic [2:0] o,
                      input logic [7:0] x, input logic [7:0] y);
    int cyc;
    logic [63:0] ehi, elo;
    logic        edz;
    ref_model(8, o, {56'd0, x}, {56'd0, y}, ehi, elo, edz);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'd10);
    chk({tag, ".hi"}, {56'd0, hi8}, ehi);
    chk({tag, ".lo"}, {56'd0, lo8}, elo);
    chk({tag, ".divzero"}, {63'd0, dz8}, {63'd0, edz});
  endtask

  initial begin
    int cyc, nbusy, nchg, ndone;
    logic [31:0] hi_prev, lo_prev, x, y;
    logic [2:0]  o;
    logic [63:0] ehi, elo;
    logic        edz;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst.hi", {32'd0, hi}, 64'd0);
    chk("rst.lo", {32'd0, lo}, 64'd0);
    chk("rst.busy", {63'd0, busy}, 64'd0);
    chk("rst.done", {63'd0, done}, 64'd0);
    chk("rst.divzero", {63'd0, dz}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_check("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max.hi_const", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
    chk("multu_max.lo_const", {32'd0, lo}, 64'h1);

    run_check("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg.hi_const", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    chk("mult_neg.lo_const", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);
    run_check("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg.lo_const", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
    chk("div_neg.hi_const", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);

    run_check("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_min_m1.lo_const", {32'd0, lo}, 64'h8000_0000);
    chk("div_min_m1.hi_const", {32'd0, hi}, 64'd0);
    run_check("divu_zero", 3'd3, 32'd100, 32'd0);
    chk("divu_zero.lo_const", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
    chk("divu_zero.hi_const", {32'd0, hi}, 64'd100);
    chk("divu_zero.dz_const", {63'd0, dz}, 64'd1);

    do_op(3'd5, 32'd5, 32'd0);
    chk("mtlo.done", {63'd0, done}, 64'd1);
    chk("mtlo.lo", {32'd0, lo}, 64'd5);
    chk("mtlo.hi_kept", {32'd0, hi}, 64'd100);
    chk("mtlo.divzero", {63'd0, dz}, 64'd0);
    chk("mtlo.busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    chk("mtlo.done_pulse", {63'd0, done}, 64'd0);
    do_op(3'd4, 32'hCAFE_0001, 32'd0);
    chk("mthi.done", {63'd0, done}, 64'd1);
    chk("mthi.hi", {32'd0, hi}, 64'h0000_0000_CAFE_0001);
    chk("mthi.lo_kept", {32'd0, lo}, 64'd5);
    do_op(3'd6, 32'h1234_5678, 32'd9);
    chk("noop.done", {63'd0, done}, 64'd0);
    chk("noop.busy", {63'd0, busy}, 64'd0);
    chk("noop.hi", {32'd0, hi}, 64'h0000_0000_CAFE_0001);

    do_op(3'd3, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(11, cyc, nbusy, nchg);
    chk("busy_start.latency", 64'(cyc), 64'd34);
    chk("busy_start.hi", {32'd0, hi}, 64'd2);
    chk("busy_start.lo", {32'd0, lo}, 64'd14);
    do_op(3'd1, 32'h0001_0001, 32'h0003_0003);
    chk("b2b.busy", {63'd0, busy}, 64'd1);
    wait_done(1, cyc, nbusy, nchg);
    chk("b2b.latency", 64'(cyc), 64'd34);
    chk("b2b.hi", {32'd0, hi}, 64'd3);
    chk("b2b.lo", {32'd0, lo}, 64'h0006_0003);

    hi_prev = hi; lo_prev = lo;
    do_op(3'd0, 32'd1234, 32'd5678);
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush.busy", {63'd0, busy}, 64'd0);
    ndone = 0; nchg = 0;
    repeat (40) begin
      if (done) ndone++;
      if (hi !== hi_prev || lo !== lo_prev) nchg++;
      @(posedge clk); #1;
    end
    chk("flush.no_done", 64'(ndone), 64'd0);
    chk("flush.hold", 64'(nchg), 64'd0);

    do_op(3'd0, 32'd1234, 32'd5678);
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.hi", {32'd0, hi}, 64'd0);
    chk("rst_mid.lo", {32'd0, lo}, 64'd0);
    chk("rst_mid.busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ndone = 0;
    repeat (40) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    chk("rst_mid.no_done", 64'(ndone), 64'd0);

    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 20));
        3: y = -32'($urandom_range(1, 20));
        default: ;
      endcase
      run_check($sformatf("rand%0d_op%0d", i, o), o, x, y);
    end

    // Interleave a move with a random divide and confirm the sticky flag clears.
    run_check("rand_dz", 3'd2, $urandom, 32'd0);
    x = $urandom;
    ref_model(32, 3'd4, {32'd0, x}, 64'd0, ehi, elo, edz);
    do_op(3'd4, x, 32'd0);
    chk("rand_mthi.hi", {32'd0, hi}, {32'd0, x});
    chk("rand_mthi.divzero", {63'd0, dz}, 64'd0);

    run8("w8_multu", 3'd1, 8'hFF, 8'hFF);
    chk("w8_multu.hi_const", {56'd0, hi8}, 64'hFE);
    chk("w8_multu.lo_const", {56'd0, lo8}, 64'h01);
    run8("w8_div_min", 3'd2, 8'h80, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      o = 3'($urandom_range(0, 3));
      run8($sformatf("w8_rand%0d_op%0d", i, o), o, 8'($urandom),
           ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
